// File: rtl/alu_pipe_p.sv
`default_nettype none
// ============================================================================
// Module   : alu_pipe_p
// Purpose  : 4-stage pipelined register-bank ALU with a valid/ready front end.
//            S1 operand fetch, S2 execute, S3 register write-back, S4 memory
//            store. Has status flags, a direct register-bank config write port
//            and a registered memory read port.
// Macro    : ALU_PIPE_FWD_EN - when defined, RAW operand forwarding from the
//            S2 combinational result and the S2 latched result is enabled.
//            When undefined, operands always come from the register bank.
// Ports    : clk, rst_n (async, active low)
//            in_valid/in_ready, rs1, rs2, rd, func, addr  - instruction input
//            cfg_we, cfg_addr, cfg_data                   - regbank direct write
//            mem_raddr -> mem_rdata (1-cycle latency)     - memory read
//            zout, out_valid, flag_z, flag_c, err         - S3 result/status
// Revision : 1.0 - initial release
// ============================================================================
module alu_pipe_p #(
    parameter int DATA_W = 16,
    parameter int RB_AW  = 4,
    parameter int MEM_AW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RB_AW-1:0]  rs1,
    input  logic [RB_AW-1:0]  rs2,
    input  logic [RB_AW-1:0]  rd,
    input  logic [3:0]        func,
    input  logic [MEM_AW-1:0] addr,
    input  logic              cfg_we,
    input  logic [RB_AW-1:0]  cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [MEM_AW-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] zout,
    output logic              out_valid,
    output logic              flag_z,
    output logic              flag_c,
    output logic              err
);

    localparam int c_NREG = 2**RB_AW;
    localparam int c_NMEM = 2**MEM_AW;

    localparam logic [3:0] c_F_ADD  = 4'd0;
    localparam logic [3:0] c_F_SUB  = 4'd1;
    localparam logic [3:0] c_F_MUL  = 4'd2;
    localparam logic [3:0] c_F_PA   = 4'd3;
    localparam logic [3:0] c_F_PB   = 4'd4;
    localparam logic [3:0] c_F_AND  = 4'd5;
    localparam logic [3:0] c_F_OR   = 4'd6;
    localparam logic [3:0] c_F_XOR  = 4'd7;
    localparam logic [3:0] c_F_NEGA = 4'd8;
    localparam logic [3:0] c_F_NEGB = 4'd9;
    localparam logic [3:0] c_F_SHR  = 4'd10;
    localparam logic [3:0] c_F_SHL  = 4'd11;

    // Register bank as a packed array so the whole bank resets in one assignment.
    logic [c_NREG-1:0][DATA_W-1:0] r_rb;
    logic [DATA_W-1:0]             r_mem [c_NMEM];

    // S1 (operand fetch) registers
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic [RB_AW-1:0]  r_s1_rd;
    logic [3:0]        r_s1_func;
    logic [MEM_AW-1:0] r_s1_addr;

    // S2 (execute) registers
    logic              r_s2_valid;
    logic [DATA_W-1:0] r_s2_z;
    logic              r_s2_c;
    logic              r_s2_err;
    logic [RB_AW-1:0]  r_s2_rd;
    logic [MEM_AW-1:0] r_s2_addr;

    // S3 (write-back) registers; r_zout doubles as the S4 store data
    logic [DATA_W-1:0] r_zout;
    logic              r_out_valid;
    logic              r_flag_z;
    logic              r_flag_c;
    logic              r_err;
    logic              r_s3_we;
    logic [MEM_AW-1:0] r_s3_addr;
    logic [DATA_W-1:0] r_mem_rdata;

    logic              w_accept;
    logic              w_s1_legal;
    logic              w_wb_we;
    logic [DATA_W-1:0] w_z;
    logic              w_c;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;

    assign in_ready   = !cfg_we;
    assign w_accept   = in_valid && in_ready;
    // func 12..15 are the only codes with both upper bits set
    assign w_s1_legal = !(r_s1_func[3] && r_s1_func[2]);
    assign w_wb_we    = r_s2_valid && !r_s2_err;

    // ------------------------------------------------------------------
    // Execute (combinational on S1 registers)
    // ------------------------------------------------------------------
    always_comb begin
        w_z = '0;
        w_c = 1'b0;
        case (r_s1_func)
            c_F_ADD:  {w_c, w_z} = {1'b0, r_s1_a} + {1'b0, r_s1_b};
            c_F_SUB: begin
                w_z = r_s1_a - r_s1_b;
                w_c = (r_s1_a < r_s1_b);
            end
            c_F_MUL:  w_z = r_s1_a * r_s1_b;
            c_F_PA:   w_z = r_s1_a;
            c_F_PB:   w_z = r_s1_b;
            c_F_AND:  w_z = r_s1_a & r_s1_b;
            c_F_OR:   w_z = r_s1_a | r_s1_b;
            c_F_XOR:  w_z = r_s1_a ^ r_s1_b;
            c_F_NEGA: w_z = -r_s1_a;
            c_F_NEGB: w_z = -r_s1_b;
            c_F_SHR:  w_z = {1'b0, r_s1_a[DATA_W-1:1]};
            c_F_SHL:  w_z = {r_s1_a[DATA_W-2:0], 1'b0};
            default: begin
                w_z = '0;
                w_c = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand selection
    // ------------------------------------------------------------------
`ifdef ALU_PIPE_FWD_EN
    // Youngest producer wins: the instruction now in execute overrides the
    // one being written back this edge, which overrides the bank.
    always_comb begin
        w_op_a = r_rb[rs1];
        if (w_wb_we && (r_s2_rd == rs1))
            w_op_a = r_s2_z;
        if (r_s1_valid && w_s1_legal && (r_s1_rd == rs1))
            w_op_a = w_z;

        w_op_b = r_rb[rs2];
        if (w_wb_we && (r_s2_rd == rs2))
            w_op_b = r_s2_z;
        if (r_s1_valid && w_s1_legal && (r_s1_rd == rs2))
            w_op_b = w_z;
    end
`else
    assign w_op_a = r_rb[rs1];
    assign w_op_b = r_rb[rs2];
`endif

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_rd     <= '0;
            r_s1_func   <= '0;
            r_s1_addr   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_z      <= '0;
            r_s2_c      <= 1'b0;
            r_s2_err    <= 1'b0;
            r_s2_rd     <= '0;
            r_s2_addr   <= '0;
            r_zout      <= '0;
            r_out_valid <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_err       <= 1'b0;
            r_s3_we     <= 1'b0;
            r_s3_addr   <= '0;
        end else begin
            // S1: operand fetch
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a    <= w_op_a;
                r_s1_b    <= w_op_b;
                r_s1_rd   <= rd;
                r_s1_func <= func;
                r_s1_addr <= addr;
            end

            // S2: execute (w_z is already 0 for illegal codes)
            r_s2_valid <= r_s1_valid;
            r_s2_z     <= w_z;
            r_s2_c     <= w_c;
            r_s2_err   <= !w_s1_legal;
            r_s2_rd    <= r_s1_rd;
            r_s2_addr  <= r_s1_addr;

            // S3: outputs are cleared in bubble cycles so they are only
            // ever non-zero alongside out_valid.
            r_out_valid <= r_s2_valid;
            r_zout      <= r_s2_valid ? r_s2_z : '0;
            r_flag_z    <= r_s2_valid && (r_s2_z == '0);
            r_flag_c    <= r_s2_valid && r_s2_c;
            r_err       <= r_s2_valid && r_s2_err;
            r_s3_we     <= w_wb_we;
            r_s3_addr   <= r_s2_addr;
        end
    end

    // Register bank: write-back is assigned last so it beats a same-index
    // cfg write in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb <= '0;
        end else begin
            if (cfg_we)
                r_rb[cfg_addr] <= cfg_data;
            if (w_wb_we)
                r_rb[r_s2_rd] <= r_s2_z;
        end
    end

    // S4 store. Not reset; r_s3_we is held low while rst_n is asserted.
    always_ff @(posedge clk) begin
        if (r_s3_we)
            r_mem[r_s3_addr] <= r_zout;
    end

    // Registered read; sees the pre-edge contents on a same-address store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_mem_rdata <= '0;
        else
            r_mem_rdata <= r_mem[mem_raddr];
    end

    assign mem_rdata = r_mem_rdata;
    assign zout      = r_zout;
    assign out_valid = r_out_valid;
    assign flag_z    = r_flag_z;
    assign flag_c    = r_flag_c;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_pipe_p
// Purpose  : Directed self-checking bench for alu_pipe_p. Expected values are
//            hand-computed; the stale-operand cases select their expectation
//            on ALU_PIPE_FWD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_p;

    localparam int DATA_W = 16;
    localparam int RB_AW  = 4;
    localparam int MEM_AW = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [RB_AW-1:0]  rs1 = '0;
    logic [RB_AW-1:0]  rs2 = '0;
    logic [RB_AW-1:0]  rd = '0;
    logic [3:0]        func = '0;
    logic [MEM_AW-1:0] addr = '0;
    logic              cfg_we = 1'b0;
    logic [RB_AW-1:0]  cfg_addr = '0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic [MEM_AW-1:0] mem_raddr = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] zout;
    logic              out_valid;
    logic              flag_z;
    logic              flag_c;
    logic              err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_pipe_p #(.DATA_W(DATA_W), .RB_AW(RB_AW), .MEM_AW(MEM_AW)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .func      (func),
        .addr      (addr),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .zout      (zout),
        .out_valid (out_valid),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] f, input logic [RB_AW-1:0] a,
                         input logic [RB_AW-1:0] b, input logic [RB_AW-1:0] d,
                         input logic [MEM_AW-1:0] ad);
        func = f; rs1 = a; rs2 = b; rd = d; addr = ad;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [RB_AW-1:0] k, input logic [DATA_W-1:0] v);
        cfg_we = 1'b1; cfg_addr = k; cfg_data = v;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic mem_read(input logic [MEM_AW-1:0] a, output logic [DATA_W-1:0] d);
        mem_raddr = a;
        tick();
        d = mem_rdata;
    endtask

    // Pass-A of rk into rk (value unchanged) and look at zout.
    task automatic reg_check(input string tag, input logic [RB_AW-1:0] k,
                             input logic [DATA_W-1:0] exp);
        issue(4'd3, k, 4'd0, k, 8'd255);
        tick();
        tick();
        check(tag, zout, exp);
    endtask

    logic [3:0]        s_func [6] = '{4'd2, 4'd1, 4'd11, 4'd1, 4'd0, 4'd7};
    logic [RB_AW-1:0]  s_rs1  [6] = '{4'd3, 4'd5, 4'd7,  4'd9, 4'd9, 4'd6};
    logic [RB_AW-1:0]  s_rs2  [6] = '{4'd8, 4'd5, 4'd0,  4'd5, 4'd5, 4'd3};
    logic [DATA_W-1:0] s_exp  [6] = '{16'd24, 16'd0, 16'd14, 16'd4, 16'd14, 16'd5};

    initial begin
        logic [DATA_W-1:0] rdv;
        logic [DATA_W-1:0] exp_r11;
        logic [DATA_W-1:0] exp_r14;

`ifdef ALU_PIPE_FWD_EN
        exp_r11 = 16'd6;
        exp_r14 = 16'd7;
`else
        exp_r11 = 16'd8;
        exp_r14 = 16'd13;
`endif

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_zout", zout, 0);
        check("rst_err", err, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_in_ready", in_ready, 1);
        rst_n = 1'b1;
        tick();

        // ---------------- cfg load r[k]=k ----------------
        cfg_we = 1'b1;
        #0;
        check("cfg_in_ready_low", in_ready, 0);
        for (int k = 0; k < 16; k++)
            cfg_write(k[RB_AW-1:0], k[DATA_W-1:0]);

        // ---------------- single ADD ----------------
        issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd125);
        tick();
        check("add_latency_e1", out_valid, 0);
        tick();
        check("add_zout", zout, 8);
        check("add_out_valid", out_valid, 1);
        check("add_flag_z", flag_z, 0);
        check("add_flag_c", flag_c, 0);
        check("add_err", err, 0);
        tick();
        check("add_out_valid_drop", out_valid, 0);
        mem_read(8'd125, rdv);
        check("add_mem125", rdv, 8);
        reg_check("add_r10", 4'd10, 8);

        // ---------------- back-to-back dependence ----------------
        cfg_write(4'd10, 16'd10);
        issue(4'd0, 4'd3, 4'd5, 4'd10, 8'd0);
        issue(4'd1, 4'd10, 4'd2, 4'd11, 8'd1);
        tick();
        check("dep_add_zout", zout, 8);
        tick();
        check("dep_sub_zout", zout, exp_r11);
        tick();
        reg_check("dep_r11", 4'd11, exp_r11);

        // distance-2 dependence (producer in write-back at consumer fetch)
        cfg_write(4'd12, 16'd12);
        issue(4'd0, 4'd3, 4'd3, 4'd12, 8'd2);
        issue(4'd4, 4'd0, 4'd0, 4'd13, 8'd3);
        issue(4'd0, 4'd12, 4'd1, 4'd14, 8'd4);
        tick();
        tick();
        check("dep2_zout", zout, exp_r14);
        tick();

        // ---------------- 6-op stream ----------------
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                func = s_func[i]; rs1 = s_rs1[i]; rs2 = s_rs2[i];
                rd = 4'd15; addr = 8'(126 + i);
                in_valid = 1'b1;
            end
            tick();
            in_valid = 1'b0;
            if (i >= 2) begin
                check($sformatf("stream_zout_%0d", i - 2), zout, s_exp[i-2]);
                check($sformatf("stream_valid_%0d", i - 2), out_valid, 1);
                check($sformatf("stream_fz_%0d", i - 2), flag_z, (s_exp[i-2] == 0) ? 1 : 0);
            end
        end
        tick();
        check("stream_valid_drop", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            mem_read(8'(126 + i), rdv);
            check($sformatf("stream_mem_%0d", 126 + i), rdv, s_exp[i]);
        end

        // ---------------- boundary arithmetic ----------------
        cfg_write(4'd1, 16'h0100);
        cfg_write(4'd2, 16'h0100);
        issue(4'd2, 4'd1, 4'd2, 4'd15, 8'd254);
        tick();
        tick();
        check("mul_ovf_zout", zout, 16'h0000);
        check("mul_ovf_fz", flag_z, 1);
        check("mul_ovf_fc", flag_c, 0);
        cfg_write(4'd1, 16'hFFFF);
        issue(4'd0, 4'd1, 4'd2, 4'd15, 8'd254);
        tick();
        tick();
        check("add_carry_zout", zout, 16'h00FF);
        check("add_carry_fc", flag_c, 1);
        tick();
        issue(4'd1, 4'd2, 4'd1, 4'd15, 8'd254);
        tick();
        tick();
        check("sub_borrow_zout", zout, 16'h0101);
        check("sub_borrow_fc", flag_c, 1);
        tick();

        // ---------------- illegal func ----------------
        issue(4'd3, 4'd6, 4'd0, 4'd6, 8'd200);
        tick();
        tick();
        tick();
        issue(4'd13, 4'd1, 4'd2, 4'd4, 8'd200);
        tick();
        tick();
        check("ill_err", err, 1);
        check("ill_zout", zout, 0);
        check("ill_valid", out_valid, 1);
        tick();
        tick();
        mem_read(8'd200, rdv);
        check("ill_mem200", rdv, 6);
        reg_check("ill_r4", 4'd4, 4);

        // ---------------- reset mid-operation ----------------
        issue(4'd3, 4'd7, 4'd0, 4'd7, 8'd50);
        tick();
        tick();
        tick();
        issue(4'd0, 4'd3, 4'd5, 4'd9, 8'd50);
        rst_n = 1'b0;
        tick();
        check("midrst_valid_a", out_valid, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_valid_b", out_valid, 0);
        tick();
        check("midrst_valid_c", out_valid, 0);
        check("midrst_zout", zout, 0);
        mem_read(8'd50, rdv);
        check("midrst_mem50", rdv, 7);
        for (int k = 0; k < 16; k++)
            reg_check($sformatf("midrst_r%0d", k), k[RB_AW-1:0], 16'd0);

        // ---------------- cfg blocks accept ----------------
        tick();
        issue(4'd0, 4'd0, 4'd0, 4'd2, 8'd60);  // keep fields set; re-drive below
        tick();
        tick();
        tick();
        func = 4'd4; rs1 = 4'd0; rs2 = 4'd1; rd = 4'd2; addr = 8'd60;
        in_valid = 1'b1;
        cfg_we = 1'b1; cfg_addr = 4'd1; cfg_data = 16'h0055;
        #0;
        check("cfgblk_in_ready", in_ready, 0);
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b0;
        tick();
        check("cfgblk_valid_e1", out_valid, 0);
        tick();
        check("cfgblk_valid_e2", out_valid, 0);
        reg_check("cfgblk_r1", 4'd1, 16'h0055);
        reg_check("cfgblk_r2", 4'd2, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
